griffin_sponge_loader: RTL and testbench
========================================

Name: griffin_sponge_loader

Overview:
- Sponge front end for the 13-lane Griffin permutation, rate 2 and capacity 1.
- Accepts a valid/ready stream of field elements and absorbs them into a 3x13 state by modular addition.
- Starts the permutation once per 26-element block, holds its input stable, captures its result, and squeezes one digest element per lane on a valid/ready output stream.
- Sits directly upstream of the permutation and drives its enable and state inputs.

Parameters:
- N_BITS, 254, field element width.
- PRIME_MODULUS, BN254 scalar prime (0x30644e72...f0000001), modulus p, N_BITS wide.
- STATE_SIZE, 3, state words per lane (words 0,1 = rate; word 2 = capacity).
- LANES, 13, parallel independent hashes.
- CAPACITY_IV, 0, initial value loaded into word 2 of every lane.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- in_valid  in  1  input element valid
- in_ready  out  1  loader can accept an element
- in_data  in  N_BITS  input element
- in_last  in  1  final element of the message batch
- perm_enable  out  1  one-cycle start pulse to the permutation
- perm_in  out  N_BITS x [STATE_SIZE][LANES]  state presented to the permutation
- perm_out  in  N_BITS x [STATE_SIZE][LANES]  permutation result
- perm_done  in  1  one-cycle completion pulse from the permutation
- out_valid  out  1  digest element valid
- out_ready  in  1  consumer accepts digest element
- out_data  out  N_BITS  digest element (state word 0 of lane out_lane)
- out_lane  out  4  lane index of out_data
- out_last  out  1  high with lane LANES-1

Behaviour:
- Reset:
  - FSM goes to ABSORB; elem_cnt=0, sq_cnt=0, last_seen=0.
  - State: words 0,1 = 0; word 2 = CAPACITY_IV in every lane.
  - perm_enable=0, out_valid=0, out_last=0, out_lane=0, out_data=0.
  - Reset mid-permutation abandons the hash; the permutation shares the reset.
- States: ABSORB, START, WAIT, SQUEEZE.
- ABSORB:
  - in_ready=1. An element is accepted when in_valid & in_ready.
  - Element number e (0..25, counted by elem_cnt) targets lane = e mod 13, word = e div 13.
  - Arithmetic: r = in_data >= p ? in_data - p : in_data. A single subtraction suffices since 2^254 < 2p.
  - s = state + r computed at N_BITS+1 width; state <= s >= p ? s - p : s. Result is always < p.
  - Block is complete when e = 25 is accepted, or when in_last is accepted at any e. Unwritten positions are left unchanged, which is implicit zero padding.
  - On block complete: elem_cnt <= 0, last_seen <= in_last, go to START.
- START:
  - perm_enable=1 for exactly one cycle; in_ready=0; then go to WAIT.
- WAIT:
  - in_ready=0. perm_in is continuously driven from the state registers, which are not modified from START until perm_done.
  - On perm_done: state <= perm_out (all 39 words). Go to SQUEEZE if last_seen, else ABSORB.
- perm_done outside WAIT is ignored.
- SQUEEZE:
  - out_valid=1, out_data=state[0][sq_cnt], out_lane=sq_cnt, out_last=(sq_cnt==12). Outputs are stable while out_ready=0.
  - On out_valid & out_ready: sq_cnt++.
  - After lane 12 is accepted: sq_cnt <= 0, last_seen <= 0, state reinitialised to the reset values, go to ABSORB.
  - in_ready=0 during SQUEEZE.
- Latency:
  - Accept of the block-completing element, then perm_enable on the next cycle.
  - perm_done, then out_valid (or in_ready) on the next cycle.
- Multi-block messages chain: the capacity and rate words carry over from perm_out into the next absorb.

Test Plan:
- Reset, then 26 elements of value 1 with in_last on the last:
  - state words 0,1 = 1 in all lanes.
  - perm_enable pulses once, one cycle after the 26th accept.
  - Stub permutation returns the identity after 20 cycles; digest stream is 13 values of 1, lanes 0..12, out_last only on lane 12.
- Modular wrap: lane 0 receives p-1 in block 1; stub returns word0 = p-1, then lane 0 receives 2 in block 2:
  - final state[0][0] = 1.
  - Input element p+5 is absorbed as 5.
- Short message: 3 elements (7, 8, 9) with in_last on the third:
  - lanes 0..2 word 0 = 7, 8, 9; all other words are 0 or CAPACITY_IV.
  - perm_enable fires after the third accept.
- Backpressure: out_ready toggles every cycle during squeeze:
  - each lane's out_data and out_lane stay stable until accepted.
  - exactly 13 transfers; in_ready stays 0 throughout squeeze.
- Spurious perm_done pulsed in ABSORB: no state change; in_ready stays 1.
- Reset asserted in WAIT:
  - next cycle state is ABSORB, in_ready=1, perm_enable=0, out_valid=0, state is back at the IV.
  - a following 1-element message hashes correctly.

Source files
------------

// File: rtl/griffin_sponge_loader_if.sv
// rtl/griffin_sponge_loader_if.sv - signal bundle between the Griffin sponge loader, its feeder, the permutation and the digest consumer
//
// Purpose: groups the input element stream, the permutation start/state/result
// handshake and the digest output stream into one interface.
//
// Ports (signals):
//   in_valid/in_ready/in_data/in_last        element stream into the loader
//   perm_enable/perm_in/perm_out/perm_done   permutation control and state
//   out_valid/out_ready/out_data/out_lane/out_last  digest stream out of the loader
// Modports:
//   slave  - the loader's view
//   master - the surrounding environment's view (feeder, permutation, consumer)
interface griffin_sponge_loader_if #(
  parameter int N_BITS     = 254,
  parameter int STATE_SIZE = 3,
  parameter int LANES      = 13
);
  logic                                          in_valid;
  logic                                          in_ready;
  logic [N_BITS-1:0]                             in_data;
  logic                                          in_last;
  logic                                          perm_enable;
  logic [STATE_SIZE-1:0][LANES-1:0][N_BITS-1:0]  perm_in;
  logic [STATE_SIZE-1:0][LANES-1:0][N_BITS-1:0]  perm_out;
  logic                                          perm_done;
  logic                                          out_valid;
  logic                                          out_ready;
  logic [N_BITS-1:0]                             out_data;
  logic [3:0]                                    out_lane;
  logic                                          out_last;

  modport slave (
    input  in_valid, in_data, in_last, perm_out, perm_done, out_ready,
    output in_ready, perm_enable, perm_in, out_valid, out_data, out_lane, out_last
  );

  modport master (
    output in_valid, in_data, in_last, perm_out, perm_done, out_ready,
    input  in_ready, perm_enable, perm_in, out_valid, out_data, out_lane, out_last
  );
endinterface

// File: rtl/griffin_sponge_loader.sv
// rtl/griffin_sponge_loader.sv - sponge absorb/permute/squeeze front end for the 13-lane Griffin permutation
//
// Purpose: absorbs a stream of field elements into a 3x13 state by modular
// addition (rate words 0,1; capacity word 2), starts the permutation once per
// 26-element block, captures its result and squeezes word 0 of each lane.
//
// Ports:
//   clk    - clock
//   reset  - synchronous, active-high
//   bus    - griffin_sponge_loader_if.slave: element stream in, permutation
//            enable/state/result/done, digest stream out
module griffin_sponge_loader #(
  parameter int                N_BITS        = 254,
  parameter logic [N_BITS-1:0] PRIME_MODULUS =
    N_BITS'(256'h30644e72e131a029b85045b68181585d2833e84879b9709143e1f593f0000001),
  parameter int                STATE_SIZE    = 3,
  parameter int                LANES         = 13,
  parameter logic [N_BITS-1:0] CAPACITY_IV   = '0
) (
  input  logic                      clk,
  input  logic                      reset,
  griffin_sponge_loader_if.slave    bus
);

  localparam int BLOCK = 2 * LANES;        // rate words absorbed per permutation
  localparam int EW    = $clog2(BLOCK);
  localparam int WW    = $clog2(STATE_SIZE);

  typedef logic [STATE_SIZE-1:0][LANES-1:0][N_BITS-1:0] state_t;
  typedef enum logic [1:0] {ST_ABSORB, ST_START, ST_WAIT, ST_SQUEEZE} fsm_t;

  function automatic state_t init_state();
    state_t s;
    s = '0;
    for (int l = 0; l < LANES; l++) s[STATE_SIZE-1][l] = CAPACITY_IV;
    return s;
  endfunction

  localparam state_t STATE_INIT = init_state();

  fsm_t              fsm_q, fsm_d;
  logic [EW-1:0]     elem_cnt_q, elem_cnt_d;
  logic [3:0]        sq_cnt_q, sq_cnt_d;
  logic              last_seen_q, last_seen_d;
  state_t            state_q, state_d;

  // Element e lands in lane e mod LANES, word e div LANES.
  logic [WW-1:0]     word_idx;
  logic [3:0]        lane_idx;
  logic [N_BITS-1:0] in_red;
  logic [N_BITS-1:0] cur_word;
  logic [N_BITS:0]   sum;
  logic [N_BITS-1:0] new_word;
  logic              in_fire;
  logic              block_done;

  always_comb begin
    if (elem_cnt_q >= EW'(LANES)) begin
      word_idx = WW'(1);
      lane_idx = 4'(elem_cnt_q - EW'(LANES));
    end else begin
      word_idx = '0;
      lane_idx = 4'(elem_cnt_q);
    end
    // One subtraction reduces any N_BITS input because 2^254 < 2p.
    in_red   = (bus.in_data >= PRIME_MODULUS) ? bus.in_data - PRIME_MODULUS : bus.in_data;
    cur_word = state_q[word_idx][lane_idx];
    sum      = {1'b0, cur_word} + {1'b0, in_red};
    new_word = (sum >= {1'b0, PRIME_MODULUS}) ? N_BITS'(sum - {1'b0, PRIME_MODULUS})
                                              : sum[N_BITS-1:0];
  end

  assign in_fire    = bus.in_valid && (fsm_q == ST_ABSORB);
  assign block_done = in_fire && (bus.in_last || (elem_cnt_q == EW'(BLOCK - 1)));

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      fsm_q       <= ST_ABSORB;
      elem_cnt_q  <= '0;
      sq_cnt_q    <= '0;
      last_seen_q <= 1'b0;
      state_q     <= STATE_INIT;
    end else begin
      fsm_q       <= fsm_d;
      elem_cnt_q  <= elem_cnt_d;
      sq_cnt_q    <= sq_cnt_d;
      last_seen_q <= last_seen_d;
      state_q     <= state_d;
    end
  end

  // Next-state logic; state words are frozen from START until perm_done so
  // perm_in stays stable for the permutation.
  always_comb begin
    fsm_d       = fsm_q;
    elem_cnt_d  = elem_cnt_q;
    sq_cnt_d    = sq_cnt_q;
    last_seen_d = last_seen_q;
    state_d     = state_q;
    case (fsm_q)
      ST_ABSORB: begin
        if (in_fire) begin
          state_d[word_idx][lane_idx] = new_word;
          if (block_done) begin
            elem_cnt_d  = '0;
            last_seen_d = bus.in_last;
            fsm_d       = ST_START;
          end else begin
            elem_cnt_d = elem_cnt_q + EW'(1);
          end
        end
      end
      ST_START: fsm_d = ST_WAIT;
      ST_WAIT: begin
        if (bus.perm_done) begin
          state_d = bus.perm_out;
          fsm_d   = last_seen_q ? ST_SQUEEZE : ST_ABSORB;
        end
      end
      ST_SQUEEZE: begin
        if (bus.out_ready) begin
          if (sq_cnt_q == 4'(LANES - 1)) begin
            sq_cnt_d    = '0;
            last_seen_d = 1'b0;
            state_d     = STATE_INIT;
            fsm_d       = ST_ABSORB;
          end else begin
            sq_cnt_d = sq_cnt_q + 4'd1;
          end
        end
      end
      default: fsm_d = ST_ABSORB;
    endcase
  end

  // Outputs
  always_comb begin
    bus.in_ready    = (fsm_q == ST_ABSORB);
    bus.perm_enable = (fsm_q == ST_START);
    bus.perm_in     = state_q;
    bus.out_valid   = 1'b0;
    bus.out_data    = '0;
    bus.out_lane    = '0;
    bus.out_last    = 1'b0;
    if (fsm_q == ST_SQUEEZE) begin
      bus.out_valid = 1'b1;
      bus.out_data  = state_q[0][sq_cnt_q];
      bus.out_lane  = sq_cnt_q;
      bus.out_last  = (sq_cnt_q == 4'(LANES - 1));
    end
  end

endmodule

// File: tb/tb_griffin_sponge_loader.sv
// tb/tb_griffin_sponge_loader.sv - self-checking bench for griffin_sponge_loader
module tb_griffin_sponge_loader;

  localparam logic [255:0] P = 256'h30644e72e131a029b85045b68181585d2833e84879b9709143e1f593f0000001;
  typedef logic [2:0][12:0][253:0] st_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  griffin_sponge_loader_if bus ();
  griffin_sponge_loader dut (.clk(clk), .reset(reset), .bus(bus));

  int errors = 0;
  int checks = 0;

  // Permutation stub: answers 20 cycles after each start pulse.
  logic stub_done = 1'b0;
  logic spur = 1'b0;
  st_t  stub_out = '0;
  int   stub_mode = 0;
  int   en_count = 0;
  bit   stub_busy = 0;
  int   stub_cnt = 0;

  assign bus.perm_done = stub_done | spur;
  assign bus.perm_out  = stub_out;

  // Reference model state and the last digest received
  logic [255:0] ms [3][13];
  logic [253:0] got [13];

  function automatic st_t fperm(input st_t s, input int mode);
    st_t r;
    logic [255:0] x, off;
    for (int w = 0; w < 3; w++)
      for (int l = 0; l < 13; l++) begin
        if (mode == 0) r[w][l] = s[w][l];
        else begin
          off = 256'(w * 13 + l + 1) * 256'h1d2c3b4a59687;
          x = ({2'b00, s[w][l]} + off) % P;
          r[w][l] = x[253:0];
        end
      end
    return r;
  endfunction

  always @(negedge clk) begin
    stub_done = 1'b0;
    if (reset) stub_busy = 0;
    else if (stub_busy) begin
      if (stub_cnt == 1) begin
        stub_out  = fperm(bus.perm_in, stub_mode);
        stub_done = 1'b1;
        stub_busy = 0;
      end else stub_cnt--;
    end else if (bus.perm_enable) begin
      stub_busy = 1;
      stub_cnt  = 20;
    end
  end

  always @(negedge clk) if (bus.perm_enable === 1'b1) en_count++;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int w = 0; w < 3; w++)
      for (int l = 0; l < 13; l++) ms[w][l] = '0;
  endtask

  function automatic logic [253:0] rnd_elem();
    logic [255:0] v;
    case ($urandom % 8)
      0: v = P - 1;
      1: v = P;
      2: v = {2'b00, {254{1'b1}}};
      default: v = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    endcase
    return v[253:0];
  endfunction

  // Called just after a negedge; returns at the negedge following the accept.
  task automatic send(input logic [253:0] d, input bit last);
    int t = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_last  = last;
    while (bus.in_ready !== 1'b1 && t < 300) begin @(negedge clk); t++; end
    checks++;
    assert (t < 300) else begin
      errors++;
      $error("FAIL send_timeout: waited %0d cycles, limit 300", t);
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  // bp: 0 always ready, 1 toggling, 2 random
  task automatic recv(input int bp);
    int t = 0;
    int n = 0;
    bit stalled = 0;
    bit rdy;
    logic [253:0] pd;
    logic [3:0] pl;
    bus.out_ready = 1'b0;
    while (bus.out_valid !== 1'b1 && t < 500) begin @(negedge clk); t++; end
    checks++;
    assert (t < 500) else begin
      errors++;
      $error("FAIL squeeze_timeout: waited %0d cycles, limit 500", t);
    end
    t = 0;
    while (n < 13 && t < 1000) begin
      rdy = (bp == 0) ? 1'b1 : (bp == 1) ? 1'(t % 2) : 1'($urandom % 2);
      bus.out_ready = rdy;
      chk("sq_in_ready", bus.in_ready, 0);
      chk("sq_valid", bus.out_valid, 1);
      if (stalled) begin
        chk("stall_data", bus.out_data, pd);
        chk("stall_lane", bus.out_lane, pl);
      end
      chk($sformatf("lane_idx%0d", n), bus.out_lane, n);
      chk($sformatf("digest%0d", n), bus.out_data, ms[0][n]);
      chk($sformatf("last%0d", n), bus.out_last, (n == 12));
      got[n] = bus.out_data;
      pd = bus.out_data;
      pl = bus.out_lane;
      stalled = !rdy;
      if (rdy) n++;
      @(negedge clk);
      t++;
    end
    bus.out_ready = 1'b0;
    chk("transfers", n, 13);
    chk("post_sq_valid", bus.out_valid, 0);
    chk("post_sq_in_ready", bus.in_ready, 1);
  endtask

  task automatic run_msg(input logic [253:0] msg[$], input int bp, input int spur_at);
    int e = 0;
    int blocks = 0;
    int en0;
    int n;
    st_t s;
    logic [255:0] x;
    n = msg.size();
    model_reset();
    en0 = en_count;
    for (int i = 0; i < n; i++) begin
      if (i == spur_at) begin
        spur = 1'b1;
        @(negedge clk);
        spur = 1'b0;
        chk("spur_in_ready", bus.in_ready, 1);
        chk("spur_no_start", bus.perm_enable, 0);
      end
      x = {2'b00, msg[i]} % P;
      ms[e / 13][e % 13] = (ms[e / 13][e % 13] + x) % P;
      send(msg[i], i == n - 1);
      if (i == n - 1 || e == 25) begin
        chk("start_pulse", bus.perm_enable, 1);
        chk("start_in_ready", bus.in_ready, 0);
        for (int w = 0; w < 3; w++)
          for (int l = 0; l < 13; l++) begin
            chk($sformatf("perm_in_w%0d_l%0d", w, l), bus.perm_in[w][l], ms[w][l]);
            s[w][l] = ms[w][l][253:0];
          end
        s = fperm(s, stub_mode);
        for (int w = 0; w < 3; w++)
          for (int l = 0; l < 13; l++) ms[w][l] = {2'b00, s[w][l]};
        blocks++;
        e = 0;
        @(negedge clk);
        chk("start_one_cycle", bus.perm_enable, 0);
      end else e++;
    end
    recv(bp);
    chk("enable_count", en_count - en0, blocks);
  endtask

  initial begin
    logic [253:0] q[$];
    logic [255:0] v;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_last   = 1'b0;
    bus.out_ready = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;

    // Reset state
    chk("rst_in_ready", bus.in_ready, 1);
    chk("rst_perm_enable", bus.perm_enable, 0);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_out_last", bus.out_last, 0);
    chk("rst_out_lane", bus.out_lane, 0);
    chk("rst_out_data", bus.out_data, 0);

    // 26 ones, identity permutation
    stub_mode = 0;
    q = {};
    for (int i = 0; i < 26; i++) q.push_back(254'd1);
    run_msg(q, 0, -1);
    for (int l = 0; l < 13; l++) chk($sformatf("ones_lane%0d", l), got[l], 1);

    // Modular wrap across two blocks
    q = {};
    v = P - 1;
    q.push_back(v[253:0]);
    for (int i = 1; i < 26; i++) q.push_back(254'd0);
    q.push_back(254'd2);
    run_msg(q, 0, -1);
    chk("wrap_lane0", got[0], 1);

    // Input p+5 absorbs as 5
    q = {};
    v = P + 5;
    q.push_back(v[253:0]);
    run_msg(q, 0, -1);
    chk("p_plus_5", got[0], 5);

    // Short message
    q = {};
    q.push_back(254'd7); q.push_back(254'd8); q.push_back(254'd9);
    run_msg(q, 0, -1);
    chk("short_l0", got[0], 7);
    chk("short_l1", got[1], 8);
    chk("short_l2", got[2], 9);
    chk("short_l3", got[3], 0);

    // Backpressure with toggling out_ready, non-trivial permutation
    stub_mode = 1;
    q = {};
    for (int i = 0; i < 10; i++) q.push_back(rnd_elem());
    run_msg(q, 1, -1);

    // Spurious perm_done while absorbing
    q = {};
    for (int i = 0; i < 20; i++) q.push_back(rnd_elem());
    run_msg(q, 0, 8);

    // Reset while waiting on the permutation
    stub_mode = 0;
    send(254'd7, 1'b1);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("wrst_in_ready", bus.in_ready, 1);
    chk("wrst_perm_enable", bus.perm_enable, 0);
    chk("wrst_out_valid", bus.out_valid, 0);
    reset = 1'b0;
    q = {};
    q.push_back(254'd11);
    run_msg(q, 0, -1);
    chk("wrst_digest", got[0], 11);

    // Randomized messages
    for (int m = 0; m < 6; m++) begin
      stub_mode = int'($urandom % 2);
      q = {};
      for (int i = 0; i < int'($urandom_range(1, 60)); i++) q.push_back(rnd_elem());
      run_msg(q, int'($urandom % 3), -1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
